uart_rx: RTL and testbench

Serial receiver for the UART peripheral. It sits between the `uart_rx_i` pin and the RX FIFO and turns asynchronous 8N1 frames into parallel bytes. It generates its own 16× oversampling tick from the programmed baud divisor. Each bit is decided by a majority vote over three mid-bit samples. Every accepted byte is pushed into the RX FIFO as a single-cycle write strobe.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receiver and transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned SAMPLE_W     = $clog2(OVERSAMPLE);
  localparam int unsigned SAMPLE_FIRST = 7;
  localparam int unsigned SAMPLE_MID   = 8;
  localparam int unsigned SAMPLE_LAST  = 9;

  // 2-of-3 majority used to decide a bit from its mid-bit samples.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversampling tick generator: a down-counter that reloads with D-1.
module uart_baud_gen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 restart_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] reload;

  // D = 0 is treated as D = 1 (reload 0, tick every clock).
  always_comb begin
    reload = (div_i == '0) ? '0 : div_i - DIV_WIDTH'(1);
    tick_o = (cnt_q == '0) && !restart_i;
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = reload;
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  // Counter state; always counts down to 0 so a divisor change cannot lock it up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronizer, 3-sample majority vote, framing FSM, FIFO strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  rx_i,
  input  logic                  fifo_full_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

  logic                  rx_meta_q, rx_s_q, rx_prev_q;
  logic                  tick, start_det, vote;
  rx_state_t             state_q, state_d;
  logic [SAMPLE_W-1:0]   s_q, s_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [1:0]            smp_q, smp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;

  // Line synchronizer plus edge-detect register; all idle high so reset never looks like a start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign start_det = (state_q == IDLE) && en_i && !rx_s_q && rx_prev_q;
  assign vote      = majority3(smp_q[0], smp_q[1], rx_s_q);

  uart_baud_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .div_i    (baud_div_i),
    .restart_i(start_det),
    .tick_o   (tick)
  );

  // Framing FSM and next-state for the shift register and result strobes.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (!en_i) begin
      state_d = IDLE;
    end else begin
      if (tick && (state_q != IDLE)) begin
        s_d = s_q + SAMPLE_W'(1);
        if (s_q == SAMPLE_W'(SAMPLE_FIRST)) smp_d[0] = rx_s_q;
        if (s_q == SAMPLE_W'(SAMPLE_MID))   smp_d[1] = rx_s_q;
      end

      unique case (state_q)
        IDLE: begin
          if (start_det) begin
            state_d = START;
            s_d     = '0;
            bit_d   = '0;
          end
        end
        START: begin
          if (tick) begin
            if ((s_q == SAMPLE_W'(SAMPLE_LAST)) && vote) begin
              state_d = IDLE;  // glitch, not a real start bit
            end else if (s_q == SAMPLE_W'(OVERSAMPLE - 1)) begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_q == SAMPLE_W'(SAMPLE_LAST)) begin
              shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
            end
            if (s_q == SAMPLE_W'(OVERSAMPLE - 1)) begin
              bit_d = bit_q + BIT_W'(1);
              if (bit_q == BIT_W'(DATA_WIDTH - 1)) state_d = STOP;
            end
          end
        end
        STOP: begin
          // Leave at mid stop bit so the next start edge can be caught with zero idle.
          if (tick && (s_q == SAMPLE_W'(SAMPLE_LAST))) begin
            state_d = IDLE;
            if (!vote) begin
              ferr_d = 1'b1;
            end else if (fifo_full_i) begin
              ovr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      s_q     <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with D = 4 (64 clocks per bit).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [15:0] baud_div;
  logic       rx;
  logic       fifo_full;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the monitor process.
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_ovr = 0, n_multi = 0, n_rise = 0, n_fall = 0;
  int rise_cyc = 0, fall_cyc = 0, pulse_cyc = 0;
  logic busy_prev = 1'b0;
  logic [7:0] vq[$];

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH(8),
    .DIV_WIDTH (16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .baud_div_i (baud_div),
    .rx_i       (rx),
    .fifo_full_i(fifo_full),
    .data_o     (data),
    .valid_o    (valid),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (busy && !busy_prev) begin n_rise = n_rise + 1; rise_cyc = cyc; end
    if (!busy && busy_prev) begin n_fall = n_fall + 1; fall_cyc = cyc; end
    busy_prev = busy;
    if (valid) begin n_valid = n_valid + 1; vq.push_back(data); pulse_cyc = cyc; end
    if (frame_err) begin n_ferr = n_ferr + 1; pulse_cyc = cyc; end
    if (overrun) begin n_ovr = n_ovr + 1; pulse_cyc = cyc; end
    if ((32'(valid) + 32'(frame_err) + 32'(overrun)) > 1) n_multi = n_multi + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is at a falling edge; hold the level for n clocks.
  task automatic send_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int skew_idx,
                            input int skew);
    for (int i = 0; i < 10; i++) begin
      logic v;
      int   n;
      v = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      n = 64 + ((i == skew_idx) ? skew : 0);
      send_bit(v, n);
    end
  endtask

  int bv, bf, bo, br, bq;

  task automatic snap();
    bv = n_valid; bf = n_ferr; bo = n_ovr; br = n_rise; bq = vq.size();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rx = 1'b1; fifo_full = 1'b0; baud_div = 16'd4;
    repeat (3) @(negedge clk);
    check_eq("reset_data", 32'(data), 32'h0);
    check_eq("reset_valid", 32'(valid), 32'h0);
    check_eq("reset_ferr", 32'(frame_err), 32'h0);
    check_eq("reset_ovr", 32'(overrun), 32'h0);
    check_eq("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);

    // Clean frame 0xA5.
    snap();
    send_frame(8'hA5, 1'b1, -1, 0);
    repeat (20) @(negedge clk);
    check_eq("a5_valid_cnt", 32'(n_valid - bv), 32'd1);
    check_eq("a5_data", 32'(data), 32'hA5);
    check_eq("a5_latency", 32'(pulse_cyc - rise_cyc), 32'd616);
    check_eq("a5_busy_fall", 32'(fall_cyc), 32'(pulse_cyc));
    check_eq("a5_busy_rises", 32'(n_rise - br), 32'd1);
    check_eq("a5_other", 32'((n_ferr - bf) + (n_ovr - bo)), 32'd0);

    // 12-clock low glitch.
    snap();
    send_bit(1'b0, 12);
    send_bit(1'b1, 100);
    check_eq("glitch_pulses", 32'((n_valid - bv) + (n_ferr - bf) + (n_ovr - bo)), 32'd0);
    check_eq("glitch_busy_rise", 32'(n_rise - br), 32'd1);
    check_eq("glitch_busy_len", 32'(fall_cyc - rise_cyc), 32'd40);

    // Frame error 0x3C.
    snap();
    send_frame(8'h3C, 1'b0, -1, 0);
    send_bit(1'b1, 20);
    check_eq("ferr_cnt", 32'(n_ferr - bf), 32'd1);
    check_eq("ferr_valid", 32'(n_valid - bv), 32'd0);
    check_eq("ferr_data_kept", 32'(data), 32'hA5);
    check_eq("ferr_latency", 32'(pulse_cyc - rise_cyc), 32'd616);

    // Overrun 0x5A.
    snap();
    fifo_full = 1'b1;
    send_frame(8'h5A, 1'b1, -1, 0);
    send_bit(1'b1, 20);
    fifo_full = 1'b0;
    check_eq("ovr_cnt", 32'(n_ovr - bo), 32'd1);
    check_eq("ovr_valid", 32'(n_valid - bv), 32'd0);
    check_eq("ovr_data_kept", 32'(data), 32'hA5);

    // Back-to-back 0x00, 0xFF, 0x81 with one long bit in the last frame.
    snap();
    send_frame(8'h00, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b1, -1, 0);
    send_frame(8'h81, 1'b1, 1, 2);
    send_bit(1'b1, 20);
    check_eq("b2b_cnt", 32'(n_valid - bv), 32'd3);
    if (vq.size() >= bq + 3) begin
      check_eq("b2b_0", 32'(vq[bq]), 32'h00);
      check_eq("b2b_1", 32'(vq[bq+1]), 32'hFF);
      check_eq("b2b_2", 32'(vq[bq+2]), 32'h81);
    end else begin
      check_eq("b2b_qsize", 32'(vq.size() - bq), 32'd3);
    end
    check_eq("b2b_errs", 32'((n_ferr - bf) + (n_ovr - bo)), 32'd0);

    // Enable dropped mid DATA, then a fresh 0x11.
    snap();
    send_bit(1'b0, 64);
    send_bit(1'b1, 64);
    send_bit(1'b0, 64);
    send_bit(1'b0, 30);
    en = 1'b0;
    @(negedge clk);
    check_eq("en_abort_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h11, 1'b1, -1, 0);
    send_bit(1'b1, 20);
    check_eq("en_valid_cnt", 32'(n_valid - bv), 32'd1);
    check_eq("en_data", 32'(data), 32'h11);
    check_eq("en_errs", 32'((n_ferr - bf) + (n_ovr - bo)), 32'd0);

    // Reset asserted mid-frame.
    send_bit(1'b0, 64);
    send_bit(1'b1, 64);
    send_bit(1'b0, 40);
    check_eq("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_data", 32'(data), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check_eq("one_hot_pulses", 32'(n_multi), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
